// File: rtl/seq_divider32.sv
// Iterative restoring divider, one quotient bit per clock, with start/done handshake.
// Optional signed support is compiled in when SIGNED_DIV_EN is defined.
module seq_divider32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signedOp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             divByZero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

   stateT            state, nextState;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] remAcc, qAcc, divReg;
   logic [WIDTH:0]   remShift;
   logic [WIDTH-1:0] trialDiff, remNext, qNext;
   logic             carry, unusedTrialMsb;
   logic [WIDTH-1:0] magDividend, magDivisor, fixQ, fixR;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (start) nextState = (divisor == '0) ? DONE : CALC;
         CALC:    if (count == LAST) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // The shifted partial remainder can reach WIDTH+1 bits for large divisors; the
   // carry out of remShift + ~divisor + 1 means "no borrow", i.e. the trial fits.
   always_comb begin
      remShift = {remAcc, qAcc[WIDTH-1]};
      {carry, unusedTrialMsb, trialDiff} =
         {1'b0, remShift} + {1'b0, ~{1'b0, divReg}} + (WIDTH + 2)'(1);
      remNext  = carry ? trialDiff : remShift[WIDTH-1:0];
      qNext    = {qAcc[WIDTH-2:0], carry};
   end

`ifdef SIGNED_DIV_EN
   logic negQ, negR;
   logic dividendNeg, divisorNeg;

   assign dividendNeg = signedOp & dividend[WIDTH-1];
   assign divisorNeg  = signedOp & divisor[WIDTH-1];
   assign magDividend = dividendNeg ? -dividend : dividend;
   assign magDivisor  = divisorNeg  ? -divisor  : divisor;
   // Truncation toward zero: remainder follows the dividend's sign.
   assign fixQ        = negQ ? -qNext   : qNext;
   assign fixR        = negR ? -remNext : remNext;

   always_ff @(posedge clk) begin
      if (!rst) begin
         negQ <= 1'b0;
         negR <= 1'b0;
      end else if (state == IDLE && start) begin
         negQ <= dividendNeg ^ divisorNeg;
         negR <= dividendNeg;
      end
   end
`else
   logic unusedSignedOp;

   assign unusedSignedOp = signedOp;
   assign magDividend    = dividend;
   assign magDivisor     = divisor;
   assign fixQ           = qNext;
   assign fixR           = remNext;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count     <= '0;
         remAcc    <= '0;
         qAcc      <= '0;
         divReg    <= '0;
         quotient  <= '0;
         remainder <= '0;
         divByZero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     divByZero <= 1'b1;
                  end else begin
                     remAcc <= '0;
                     qAcc   <= magDividend;
                     divReg <= magDivisor;
                     count  <= '0;
                  end
               end
            end
            CALC: begin
               remAcc <= remNext;
               qAcc   <= qNext;
               count  <= count + CW'(1);
               if (count == LAST) begin
                  quotient  <= fixQ;
                  remainder <= fixR;
                  divByZero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: vector table plus reset and handshake sequences.
// Expected results for signed vectors follow whether SIGNED_DIV_EN is defined.
module tb_seq_divider32;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             signedOp = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic             busy, done, divByZero;
   logic [WIDTH-1:0] quotient, remainder;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   seq_divider32 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .signedOp  (signedOp),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .divByZero (divByZero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          edges;
   } VecRec;

   VecRec vecs[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Steps edges until done is seen or the budget runs out; start drops after edge dropAt.
   task automatic waitDone(input int budget, input int dropAt, output int edges, output int busyCycles);
      edges = 0;
      busyCycles = 0;
      while (edges < budget) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == dropAt) start = 1'b0;
         if (busy === 1'b1) busyCycles++;
         if (done === 1'b1) break;
      end
   endtask

   task automatic runVec(input VecRec v, input string tag);
      int edges, busyCycles;
      dividend = v.a;
      divisor  = v.b;
      signedOp = v.s;
      start    = 1'b1;
      waitDone(60, 1, edges, busyCycles);
      check({tag, " latency"}, edges, v.edges);
      check({tag, " busy cycles"}, busyCycles, v.edges - 1);
      check({tag, " quotient"}, quotient, v.q);
      check({tag, " remainder"}, remainder, v.r);
      check({tag, " divByZero"}, divByZero, v.dbz);
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, done, 1'b0);
   endtask

   initial begin
      int edges, busyCycles;

      vecs.push_back(VecRec'{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33});
      vecs.push_back(VecRec'{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33});
      vecs.push_back(VecRec'{32'd32768, 32'd32768, 1'b0, 32'd1, 32'd0, 1'b0, 33});
      vecs.push_back(VecRec'{32'd1234567, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234567, 1'b1, 1});
      vecs.push_back(VecRec'{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0, 33});
      vecs.push_back(VecRec'{32'd1000000, 32'd3, 1'b0, 32'd333333, 32'd1, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FF9C, 32'd7, 1'b0, 32'h2492_4916, 32'd2, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1});
`ifdef SIGNED_DIV_EN
      vecs.push_back(VecRec'{32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33});
      vecs.push_back(VecRec'{32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 33});
      vecs.push_back(VecRec'{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 33});
`else
      vecs.push_back(VecRec'{32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2, 1'b0, 33});
      vecs.push_back(VecRec'{32'd100, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'd100, 1'b0, 33});
      vecs.push_back(VecRec'{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33});
      vecs.push_back(VecRec'{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'hFFFF_FFF9, 1'b0, 33});
`endif

      // Reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset divByZero", divByZero, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

      // Reset mid-operation discards the op and clears the held results
      dividend = 32'd100;
      divisor  = 32'd7;
      signedOp = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("midreset busy before", busy, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midreset busy", busy, 1'b0);
      check("midreset done", done, 1'b0);
      check("midreset quotient", quotient, 32'd0);
      check("midreset remainder", remainder, 32'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midreset stays idle", busy, 1'b0);
      runVec(vecs[0], "postreset");

      // Handshake: start held through CALC with new operands, then re-launch after DONE
      dividend = 32'd45042;
      divisor  = 32'd5045;
      signedOp = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      check("hs busy", busy, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      dividend = 32'd5;
      divisor  = 32'd1;
      waitDone(60, 0, edges, busyCycles);
      check("hs first latency", edges, 29);
      check("hs first quotient", quotient, 32'd8);
      check("hs first remainder", remainder, 32'd4682);
      @(posedge clk);
      #1;
      check("hs idle done", done, 1'b0);
      check("hs idle busy", busy, 1'b0);
      @(posedge clk);
      #1;
      check("hs relaunch busy", busy, 1'b1);
      check("hs held quotient", quotient, 32'd8);
      check("hs held remainder", remainder, 32'd4682);
      start = 1'b0;
      waitDone(60, 0, edges, busyCycles);
      check("hs second latency", edges, 32);
      check("hs second quotient", quotient, 32'd5);
      check("hs second remainder", remainder, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
